cntr_limit_sequencer: RTL

//  Sequencer for the synchronised limit counter (q counts 0..limit, done on wrap).

---
 rtl/cntr_limit_sequencer_if.sv | 29 ++
 rtl/cntr_limit_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cntr_limit_sequencer_if.sv
// Host-side bus of cntr_limit_sequencer: table write port, start/abort
// controls and sequence status. master = host, slave = sequencer.
interface cntr_limit_sequencer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = 8,
  parameter int unsigned RW    = 4
);
  localparam int unsigned IW = $clog2(DEPTH);

  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [LW-1:0] wr_limit;
  logic [RW-1:0] wr_reps;
  logic          start;
  logic          abort;
  logic [IW-1:0] cur_idx;
  logic          busy;
  logic          seq_done;

  modport master (
    output wr_en, wr_addr, wr_limit, wr_reps, start, abort,
    input  cur_idx, busy, seq_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_limit, wr_reps, start, abort,
    output cur_idx, busy, seq_done
  );
endinterface

// File: rtl/cntr_limit_sequencer.sv
// Sequencer for the synchronised limit counter. Walks a DEPTH-entry table of
// {limit, repeat count}, enabling the counter for each entry until it has
// wrapped 'repeat count' times, with a GAP_CYC enable-low gap between entries
// so late synchronised wraps are flushed. Entries with repeat count 0 are skipped.
// Optional feature: define CNTR_SEQ_LOOP_EN to restart the table after each lap
// until abort (a lap that ran no entry returns to idle instead).
module cntr_limit_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LW      = 8,
  parameter int unsigned RW      = 4,
  parameter int unsigned GAP_CYC = 3
) (
  input  logic                    clk,
  input  logic                    rst_n_2,
  cntr_limit_sequencer_if.slave   host,
  input  logic                    cntr_done,
  output logic                    cntr_ena,
  output logic [LW-1:0]           cntr_limit
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]    state;
  logic [LW-1:0] tbl_limit [DEPTH];
  logic [RW-1:0] tbl_reps  [DEPTH];
  logic [RW-1:0] rep_cnt;
  logic [GW-1:0] gap_cnt;
  logic [IW-1:0] cur_idx;
  logic          busy;
  logic          seq_done;
  logic          last_idx;
`ifdef CNTR_SEQ_LOOP_EN
  logic          ran_any;
`endif

  assign last_idx      = (cur_idx == IW'(DEPTH - 1));
  assign host.cur_idx  = cur_idx;
  assign host.busy     = busy;
  assign host.seq_done = seq_done;

  // Entry table: host writes land only while the sequencer is idle
  always_ff @(posedge clk or negedge rst_n_2) begin
    if (!rst_n_2) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_limit[i] <= '0;
        tbl_reps[i]  <= '0;
      end
    end else if (host.wr_en && !busy) begin
      tbl_limit[host.wr_addr] <= host.wr_limit;
      tbl_reps[host.wr_addr]  <= host.wr_reps;
    end
  end

  // Sequencer FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge clk or negedge rst_n_2) begin
    if (!rst_n_2) begin
      state      <= S_IDLE;
      cur_idx    <= '0;
      rep_cnt    <= '0;
      gap_cnt    <= '0;
      cntr_ena   <= 1'b0;
      cntr_limit <= '0;
      busy       <= 1'b0;
      seq_done   <= 1'b0;
`ifdef CNTR_SEQ_LOOP_EN
      ran_any    <= 1'b0;
`endif
    end else if (host.abort) begin
      state    <= S_IDLE;
      cur_idx  <= '0;
      rep_cnt  <= '0;
      gap_cnt  <= '0;
      cntr_ena <= 1'b0;
      busy     <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (host.start) begin
            state   <= S_LOAD;
            cur_idx <= '0;
            busy    <= 1'b1;
`ifdef CNTR_SEQ_LOOP_EN
            ran_any <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (tbl_reps[cur_idx] == '0) begin
            if (last_idx) begin
              state    <= S_FIN;
              seq_done <= 1'b1;
            end else begin
              cur_idx <= cur_idx + IW'(1);
            end
          end else begin
            cntr_limit <= tbl_limit[cur_idx];
            rep_cnt    <= tbl_reps[cur_idx];
            cntr_ena   <= 1'b1;
            state      <= S_RUN;
`ifdef CNTR_SEQ_LOOP_EN
            ran_any    <= 1'b1;
`endif
          end
        end
        S_RUN: begin
          if (cntr_done) begin
            rep_cnt <= rep_cnt - RW'(1);
            if (rep_cnt == RW'(1)) begin
              state    <= S_GAP;
              cntr_ena <= 1'b0;
              gap_cnt  <= '0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            gap_cnt <= '0;
            if (last_idx) begin
              state    <= S_FIN;
              seq_done <= 1'b1;
            end else begin
              cur_idx <= cur_idx + IW'(1);
              state   <= S_LOAD;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        S_FIN: begin
`ifdef CNTR_SEQ_LOOP_EN
          // a lap that ran nothing would spin forever, so it ends the sequence
          if (ran_any) begin
            state   <= S_LOAD;
            cur_idx <= '0;
            ran_any <= 1'b0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
`else
          state <= S_IDLE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state    <= S_IDLE;
          cntr_ena <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule
